// File: rtl/lut_cfg_if.sv
// Serial configuration bus between a bitstream source and lut_cfg_loader.
// Carries the load handshake plus the committed mask word and status flags.
interface lut_cfg_if #(
   parameter int TOTAL = 32
);
   logic             cfg_start;
   logic             cfg_bit;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [TOTAL-1:0] masks;
   logic             cfg_busy;
   logic             cfg_done;
   logic             cfg_err;

   modport master (
      output cfg_start, cfg_bit, cfg_valid,
      input  cfg_ready, masks, cfg_busy, cfg_done, cfg_err
   );

   modport slave (
      input  cfg_start, cfg_bit, cfg_valid,
      output cfg_ready, masks, cfg_busy, cfg_done, cfg_err
   );
endinterface

// File: rtl/lut_cfg_loader.sv
// Serial LUT mask loader: shifts TOTAL bits into a shadow register, then commits all masks at once.
// Optional even-parity trailer bit is enabled by defining CFG_PARITY_EN.
module lut_cfg_loader #(
   parameter int NUM_LUTS = 4,
   parameter int MASK_W   = 8
) (
   input logic        i_clk,
   input logic        i_rst,
   lut_cfg_if.slave   bus
);
   localparam int TOTAL = NUM_LUTS * MASK_W;
   localparam int CNT_W = $clog2(TOTAL + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_PARITY = 3'd2,
      ST_COMMIT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

`ifdef CFG_PARITY_EN
   function automatic logic f_parity(input logic [TOTAL-1:0] v);
      return ^v;
   endfunction
`endif

   state_t             r_state;
   logic [TOTAL-1:0]   r_shadow;
   logic [CNT_W-1:0]   r_count;
   logic [TOTAL-1:0]   r_masks;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;
   logic               r_err;

   state_t             w_state_nxt;
   logic [TOTAL-1:0]   w_shadow_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [TOTAL-1:0]   w_masks_nxt;
   logic               w_ready_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_err_nxt;
   logic               w_accept;

   // Next-state and next-register logic; ready/busy are precomputed so outputs come straight from flops.
   always_comb begin
      w_state_nxt  = r_state;
      w_shadow_nxt = r_shadow;
      w_count_nxt  = r_count;
      w_masks_nxt  = r_masks;
      w_done_nxt   = r_done;
      w_err_nxt    = r_err;
      w_accept     = bus.cfg_valid & r_ready;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.cfg_start) begin
               w_state_nxt  = ST_LOAD;
               w_count_nxt  = {CNT_W{1'b0}};
               w_shadow_nxt = {TOTAL{1'b0}};
               w_done_nxt   = 1'b0;
               w_err_nxt    = 1'b0;
            end else begin
               w_state_nxt  = r_state;
            end
         end
         ST_LOAD: begin
            if (w_accept) begin
               w_shadow_nxt = {r_shadow[TOTAL-2:0], bus.cfg_bit};
               w_count_nxt  = r_count + CNT_W'(1);
               if (r_count == CNT_W'(TOTAL - 1)) begin
`ifdef CFG_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_COMMIT;
`endif
               end else begin
                  w_state_nxt = ST_LOAD;
               end
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
`ifdef CFG_PARITY_EN
         ST_PARITY: begin
            if (w_accept) begin
               // Even parity over data plus trailer; a bad load never reaches the masks.
               if ((f_parity(r_shadow) ^ bus.cfg_bit) == 1'b0) begin
                  w_state_nxt = ST_COMMIT;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_err_nxt   = 1'b1;
               end
            end else begin
               w_state_nxt = ST_PARITY;
            end
         end
`endif
         ST_COMMIT: begin
            w_masks_nxt = r_shadow;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_ready_nxt = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_PARITY);
      w_busy_nxt  = w_ready_nxt || (w_state_nxt == ST_COMMIT);
   end

   // State and datapath registers with synchronous reset that also clears the committed masks.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_shadow <= {TOTAL{1'b0}};
         r_count  <= {CNT_W{1'b0}};
         r_masks  <= {TOTAL{1'b0}};
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         r_count  <= w_count_nxt;
         r_masks  <= w_masks_nxt;
         r_ready  <= w_ready_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign bus.cfg_ready = r_ready;
   assign bus.cfg_busy  = r_busy;
   assign bus.cfg_done  = r_done;
   assign bus.masks     = r_masks;
`ifdef CFG_PARITY_EN
   assign bus.cfg_err   = r_err;
`else
   assign bus.cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Randomized bench for lut_cfg_loader (NUM_LUTS=2, MASK_W=8) against a bit-queue reference model.
// Build with CFG_PARITY_EN defined to also exercise the parity trailer.
module tb_lut_cfg_loader;
   localparam int NUM_LUTS = 2;
   localparam int MASK_W   = 8;
   localparam int TOTAL    = NUM_LUTS * MASK_W;
`ifdef CFG_PARITY_EN
   localparam int NBITS = TOTAL + 1;
`else
   localparam int NBITS = TOTAL;
`endif

   logic clk;
   logic rst;
   int   n_err;
   int   n_chk;
   bit   chk_en;

   lut_cfg_if #(.TOTAL(TOTAL)) bus ();

   lut_cfg_loader #(.NUM_LUTS(NUM_LUTS), .MASK_W(MASK_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: collects accepted bits in a queue, first bit ends up as the MSB.
   bit          m_loading;
   bit          m_par_wait;
   bit          m_commit;
   bit          m_q[$];
   logic [15:0] m_pending;
   logic [15:0] m_masks;
   bit          m_done;
   bit          m_err;

   always @(posedge clk) begin
      if (rst) begin
         m_loading = 0; m_par_wait = 0; m_commit = 0; m_q.delete();
         m_masks = 16'h0000; m_done = 0; m_err = 0;
      end else if (m_commit) begin
         m_masks = m_pending; m_done = 1; m_commit = 0;
      end else if (m_loading || m_par_wait) begin
         if (bus.cfg_valid) begin
            if (m_loading) begin
               m_q.push_back(bus.cfg_bit);
               if (m_q.size() == TOTAL) begin
                  m_pending = 16'h0000;
                  foreach (m_q[i]) m_pending = {m_pending[14:0], m_q[i]};
                  m_loading = 0;
                  if (NBITS > TOTAL) m_par_wait = 1;
                  else m_commit = 1;
               end
            end else begin
               m_par_wait = 0;
               if (($countones(m_pending) + int'(bus.cfg_bit)) % 2 == 0) m_commit = 1;
               else m_err = 1;
            end
         end
      end else if (bus.cfg_start) begin
         m_loading = 1; m_q.delete(); m_done = 0; m_err = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_masks", 32'(bus.masks), 32'(m_masks));
         chk("cyc_ready", 32'(bus.cfg_ready), 32'(m_loading || m_par_wait));
         chk("cyc_busy",  32'(bus.cfg_busy), 32'(m_loading || m_par_wait || m_commit));
         chk("cyc_done",  32'(bus.cfg_done), 32'(m_done));
         chk("cyc_err",   32'(bus.cfg_err), 32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_pulse();
      bus.cfg_start = 1'b1;
      bus.cfg_valid = 1'b1;            // same-cycle valid in IDLE/DONE must be ignored
      bus.cfg_bit   = 1'($urandom);
      tick();
      bus.cfg_start = 1'b0;
      bus.cfg_valid = 1'b0;
   endtask

   task automatic send_bits(input logic [16:0] seq, input int n, input int gap_pct, input bit noise);
      for (int k = 0; k < n; k++) begin
         bit acc;
         int tries;
         acc = 0;
         tries = 0;
         while (!acc && tries < 64) begin
            if (int'($urandom_range(99)) < gap_pct) begin
               bus.cfg_valid = 1'b0;
               bus.cfg_bit   = 1'($urandom);
            end else begin
               bus.cfg_valid = 1'b1;
               bus.cfg_bit   = seq[16-k];
            end
            bus.cfg_start = noise ? ($urandom_range(2) == 0) : 1'b0;
            acc = bus.cfg_valid && bus.cfg_ready;
            tick();
            tries++;
         end
         if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      end
      bus.cfg_valid = 1'b0;
      bus.cfg_start = 1'b0;
   endtask

   task automatic load(input logic [15:0] val, input logic par, input int gap_pct, input bit noise);
      start_pulse();
      send_bits({val, par}, NBITS, gap_pct, noise);
   endtask

   initial begin
      logic [15:0] rv;
      logic        rp;
      n_err = 0; n_chk = 0; chk_en = 0;
      rst = 1'b1;
      bus.cfg_start = 1'b0; bus.cfg_bit = 1'b0; bus.cfg_valid = 1'b0;
      tick(); tick();
      chk_en = 1;
      chk("rst_masks", 32'(bus.masks), 32'h0000);
      chk("rst_ready", 32'(bus.cfg_ready), 32'd0);
      chk("rst_busy",  32'(bus.cfg_busy), 32'd0);
      chk("rst_done",  32'(bus.cfg_done), 32'd0);
      chk("rst_err",   32'(bus.cfg_err), 32'd0);
      rst = 1'b0;
      tick();

      // Back-to-back load: masks appear two edges after the final accept.
      load(16'hA55A, 1'b0, 0, 0);
      chk("a55a_commit_cycle_old", 32'(bus.masks), 32'h0000);
      tick();
      chk("a55a_masks", 32'(bus.masks), 32'hA55A);
      chk("a55a_lut1", 32'(bus.masks[15:8]), 32'hA5);
      chk("a55a_lut0", 32'(bus.masks[7:0]), 32'h5A);
      chk("a55a_done", 32'(bus.cfg_done), 32'd1);
      chk("model_a55a", 32'(m_masks), 32'hA55A);
      tick();

      // Gapped load: old masks stay visible throughout.
      start_pulse();
      send_bits({16'h3C96, ^16'h3C96}, NBITS / 2, 50, 0);
      chk("gap_mid_masks", 32'(bus.masks), 32'hA55A);
      chk("gap_mid_done",  32'(bus.cfg_done), 32'd0);
      send_bits({16'h3C96, ^16'h3C96} << (NBITS / 2), NBITS - NBITS / 2, 50, 0);
      chk("gap_commit_cycle_old", 32'(bus.masks), 32'hA55A);
      tick();
      chk("gap_masks", 32'(bus.masks), 32'h3C96);
      tick();

      // Reset during a load clears the masks; a fresh load still works.
      load(16'h1234, ^16'h1234, 20, 0);
      tick(); tick();
      chk("l1234_masks", 32'(bus.masks), 32'h1234);
      start_pulse();
      send_bits({16'h5678, 1'b0}, 8, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_masks", 32'(bus.masks), 32'h0000);
      chk("abort_ready", 32'(bus.cfg_ready), 32'd0);
      chk("abort_busy",  32'(bus.cfg_busy), 32'd0);
      tick();
      load(16'hFFFF, 1'b0, 0, 0);
      tick(); tick();
      chk("ffff_masks", 32'(bus.masks), 32'hFFFF);
      chk("model_ffff", 32'(m_masks), 32'hFFFF);

      // Stray start pulses during a load are ignored.
      load(16'hA55A, 1'b0, 30, 1);
      tick(); tick();
      chk("noise_masks", 32'(bus.masks), 32'hA55A);
      chk("noise_done",  32'(bus.cfg_done), 32'd1);

`ifdef CFG_PARITY_EN
      load(16'hA55A, 1'b0, 0, 0);
      tick(); tick();
      chk("par_ok_masks", 32'(bus.masks), 32'hA55A);
      chk("par_ok_done",  32'(bus.cfg_done), 32'd1);
      load(16'h0001, 1'b0, 0, 0);
      tick(); tick();
      chk("par_bad_err",   32'(bus.cfg_err), 32'd1);
      chk("par_bad_masks", 32'(bus.masks), 32'hA55A);
      chk("par_bad_done",  32'(bus.cfg_done), 32'd0);
      chk("model_par_err", 32'(m_err), 32'd1);
`endif

      // Randomized loads, checked by the per-cycle compare.
      for (int n = 0; n < 25; n++) begin
         rv = 16'($urandom);
         rp = (^rv) ^ ($urandom_range(3) == 0);
         load(rv, rp, int'($urandom_range(60)), 1'($urandom));
         repeat (int'($urandom_range(1, 4))) tick();
      end

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1);
   end
endmodule
